// File: rtl/gecko_register_commit_if.sv
`default_nettype none
// ============================================================================
// Module      : gecko_register_commit_if
// Description : Writeback and reservation handshakes into the commit stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface gecko_register_commit_if;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_value;
  logic [4:0]  wb_addr;
  logic        wb_speculative;
  logic        wb_jump_flag;
  logic        reserve_valid;
  logic        reserve_ready;
  logic [4:0]  reserve_addr;

  modport master (
    output wb_valid, wb_value, wb_addr, wb_speculative, wb_jump_flag,
    output reserve_valid, reserve_addr,
    input  wb_ready, reserve_ready
  );

  modport slave (
    input  wb_valid, wb_value, wb_addr, wb_speculative, wb_jump_flag,
    input  reserve_valid, reserve_addr,
    output wb_ready, reserve_ready
  );
endinterface
`default_nettype wire

// File: rtl/gecko_register_commit.sv
`default_nettype none
// ============================================================================
// Module      : gecko_register_commit
// Description : Commits writeback results to the 32x32 register file, tracks
//               per-register write reservations and holds one speculative
//               result until its branch resolves. Optional macro
//               GECKO_COMMIT_BYPASS_EN forwards same-cycle commits to reads.
// Revision    : 1.0 - initial release
// ============================================================================
module gecko_register_commit #(
  parameter int unsigned RESERVE_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  gecko_register_commit_if.slave bus,
  input  logic                   spec_commit,
  input  logic                   spec_flush,
  input  logic [4:0]             rs1_addr,
  input  logic [4:0]             rs2_addr,
  output logic [31:0]            rs1_value,
  output logic [31:0]            rs2_value,
  output logic                   rs1_ready,
  output logic                   rs2_ready,
  output logic [31:0]            retired_count,
  output logic [31:0]            jump_count,
  output logic                   underflow_err
);
  localparam logic [RESERVE_WIDTH-1:0] c_cnt_max = '1;

  logic                     en_q;
  logic [31:0]              regs_q [32];
  logic [31:0]              regs_d [32];
  logic [RESERVE_WIDTH-1:0] cnt_q [32];
  logic [RESERVE_WIDTH-1:0] cnt_d [32];
  logic                     hold_valid_q, hold_valid_d;
  logic [4:0]               hold_addr_q, hold_addr_d;
  logic [31:0]              hold_value_q, hold_value_d;
  logic                     hold_jump_q, hold_jump_d;
  logic [31:0]              retired_q, retired_d;
  logic [31:0]              jumps_q, jumps_d;
  logic                     underflow_q, underflow_d;

  logic                     wb_fire, res_fire;
  logic                     wr_en, wr_jump, rel_en;
  logic [4:0]               wr_addr, rel_addr;
  logic [31:0]              wr_value;

  // Handshakes stay low until the first clock after reset release.
  assign bus.wb_ready      = en_q && !hold_valid_q;
  assign bus.reserve_ready = en_q && ((bus.reserve_addr == 5'd0) ||
                                      (cnt_q[bus.reserve_addr] != c_cnt_max));
  assign wb_fire  = bus.wb_valid && bus.wb_ready;
  assign res_fire = bus.reserve_valid && bus.reserve_ready;

  // At most one commit/release per cycle: wb is stalled while the hold is full.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_value = 32'd0;
    wr_jump  = 1'b0;
    rel_en   = 1'b0;
    rel_addr = 5'd0;
    if (hold_valid_q && spec_flush) begin
      rel_en   = 1'b1;
      rel_addr = hold_addr_q;
    end else if (hold_valid_q && spec_commit) begin
      wr_en    = 1'b1;
      wr_addr  = hold_addr_q;
      wr_value = hold_value_q;
      wr_jump  = hold_jump_q;
      rel_en   = 1'b1;
      rel_addr = hold_addr_q;
    end else if (wb_fire && !bus.wb_speculative) begin
      wr_en    = 1'b1;
      wr_addr  = bus.wb_addr;
      wr_value = bus.wb_value;
      wr_jump  = bus.wb_jump_flag;
      rel_en   = 1'b1;
      rel_addr = bus.wb_addr;
    end
  end

  always_comb begin
    regs_d       = regs_q;
    cnt_d        = cnt_q;
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_value_d = hold_value_q;
    hold_jump_d  = hold_jump_q;
    retired_d    = retired_q;
    jumps_d      = jumps_q;
    underflow_d  = underflow_q;

    if (wr_en && (wr_addr != 5'd0)) regs_d[wr_addr] = wr_value;
    if (wr_en) begin
      retired_d = retired_q + 32'd1;
      if (wr_jump) jumps_d = jumps_q + 32'd1;
    end

    // x0 is skipped: its counter is pinned at zero.
    for (int i = 1; i < 32; i++) begin
      if (res_fire && (bus.reserve_addr == i[4:0]) && !(rel_en && (rel_addr == i[4:0]))) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end else if (rel_en && (rel_addr == i[4:0]) && !(res_fire && (bus.reserve_addr == i[4:0]))) begin
        if (cnt_q[i] == '0) underflow_d = 1'b1;
        else                cnt_d[i]    = cnt_q[i] - 1'b1;
      end
    end

    if (hold_valid_q && (spec_flush || spec_commit)) hold_valid_d = 1'b0;
    if (wb_fire && bus.wb_speculative) begin
      hold_valid_d = 1'b1;
      hold_addr_d  = bus.wb_addr;
      hold_value_d = bus.wb_value;
      hold_jump_d  = bus.wb_jump_flag;
    end
  end

  always_comb begin
    rs1_value = (rs1_addr == 5'd0) ? 32'd0 : regs_q[rs1_addr];
    rs2_value = (rs2_addr == 5'd0) ? 32'd0 : regs_q[rs2_addr];
    rs1_ready = (cnt_q[rs1_addr] == '0);
    rs2_ready = (cnt_q[rs2_addr] == '0);
`ifdef GECKO_COMMIT_BYPASS_EN
    if (wr_en && (wr_addr == rs1_addr) && (rs1_addr != 5'd0)) begin
      rs1_value = wr_value;
      rs1_ready = (cnt_d[rs1_addr] == '0);
    end
    if (wr_en && (wr_addr == rs2_addr) && (rs2_addr != 5'd0)) begin
      rs2_value = wr_value;
      rs2_ready = (cnt_d[rs2_addr] == '0);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q         <= 1'b0;
      regs_q       <= '{default: '0};
      cnt_q        <= '{default: '0};
      hold_valid_q <= 1'b0;
      hold_addr_q  <= 5'd0;
      hold_value_q <= 32'd0;
      hold_jump_q  <= 1'b0;
      retired_q    <= 32'd0;
      jumps_q      <= 32'd0;
      underflow_q  <= 1'b0;
    end else begin
      en_q         <= 1'b1;
      regs_q       <= regs_d;
      cnt_q        <= cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_value_q <= hold_value_d;
      hold_jump_q  <= hold_jump_d;
      retired_q    <= retired_d;
      jumps_q      <= jumps_d;
      underflow_q  <= underflow_d;
    end
  end

  assign retired_count = retired_q;
  assign jump_count    = jumps_q;
  assign underflow_err = underflow_q;
endmodule
`default_nettype wire

// File: tb/tb_gecko_register_commit.sv
`default_nettype none
// ============================================================================
// Module      : tb_gecko_register_commit
// Description : Directed scenarios plus randomized traffic against a
//               behavioural model of the commit stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gecko_register_commit;
  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        spec_commit, spec_flush;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_value, rs2_value, retired_count, jump_count;
  logic        rs1_ready, rs2_ready, underflow_err;

  always #5 clk = ~clk;

  gecko_register_commit_if bus ();

  gecko_register_commit #(.RESERVE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .spec_commit(spec_commit), .spec_flush(spec_flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_ready(rs1_ready), .rs2_ready(rs2_ready),
    .retired_count(retired_count), .jump_count(jump_count),
    .underflow_err(underflow_err)
  );

  // Behavioural model state
  logic [31:0] m_regs [32];
  int          m_cnt [32];
  bit          m_hold_v, m_hold_j, m_under, m_en;
  logic [4:0]  m_hold_a;
  logic [31:0] m_hold_d, m_ret, m_jmp;

  int n_cmp = 0;
  int n_err = 0;

  function automatic bit m_wb_ready();
    return m_en && !m_hold_v;
  endfunction

  function automatic bit m_res_ready(input logic [4:0] a);
    return m_en && ((a == 5'd0) || (m_cnt[a] < MAXC));
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) begin m_regs[i] = 32'd0; m_cnt[i] = 0; end
    m_hold_v = 0; m_hold_j = 0; m_hold_a = 5'd0; m_hold_d = 32'd0;
    m_ret = 32'd0; m_jmp = 32'd0; m_under = 0; m_en = 0;
  endfunction

  function automatic void m_commit(input logic [4:0] a, input logic [31:0] d, input bit j);
    if (a != 5'd0) m_regs[a] = d;
    m_ret = m_ret + 32'd1;
    if (j) m_jmp = m_jmp + 32'd1;
  endfunction

  function automatic void model_edge();
    bit wf, rf;
    int rel;
    wf  = bus.wb_valid && m_wb_ready();
    rf  = bus.reserve_valid && m_res_ready(bus.reserve_addr);
    rel = -1;
    if (m_hold_v && spec_flush) begin
      rel = int'(m_hold_a); m_hold_v = 0;
    end else if (m_hold_v && spec_commit) begin
      m_commit(m_hold_a, m_hold_d, m_hold_j); rel = int'(m_hold_a); m_hold_v = 0;
    end else if (wf && !bus.wb_speculative) begin
      m_commit(bus.wb_addr, bus.wb_value, bus.wb_jump_flag); rel = int'(bus.wb_addr);
    end
    if (wf && bus.wb_speculative) begin
      m_hold_v = 1; m_hold_a = bus.wb_addr; m_hold_d = bus.wb_value; m_hold_j = bus.wb_jump_flag;
    end
    if (rf && bus.reserve_addr != 5'd0 && rel != int'(bus.reserve_addr))
      m_cnt[bus.reserve_addr] = m_cnt[bus.reserve_addr] + 1;
    if (rel > 0 && !(rf && rel == int'(bus.reserve_addr))) begin
      if (m_cnt[rel] == 0) m_under = 1;
      else                 m_cnt[rel] = m_cnt[rel] - 1;
    end
    m_en = 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic idle();
    bus.wb_valid = 0; bus.wb_speculative = 0; bus.wb_jump_flag = 0;
    bus.reserve_valid = 0; spec_commit = 0; spec_flush = 0;
  endtask

  task automatic do_reserve(input logic [4:0] a);
    bus.reserve_valid = 1; bus.reserve_addr = a;
    tick(); idle();
  endtask

  task automatic do_wb(input logic [4:0] a, input logic [31:0] d, input bit sp, input bit j);
    bus.wb_valid = 1; bus.wb_addr = a; bus.wb_value = d; bus.wb_speculative = sp; bus.wb_jump_flag = j;
    tick(); idle();
  endtask

  task automatic test_reset();
    rst = 0; idle(); bus.wb_addr = 0; bus.wb_value = 0; bus.reserve_addr = 0;
    rs1_addr = 0; rs2_addr = 0; model_reset();
    #1;
    n_cmp++; if (bus.wb_ready !== 1'b0) begin n_err++; $display("FAIL reset_wb_ready got %b want 0", bus.wb_ready); end
    n_cmp++; if (bus.reserve_ready !== 1'b0) begin n_err++; $display("FAIL reset_reserve_ready got %b want 0", bus.reserve_ready); end
    n_cmp++; if (retired_count !== 32'd0 || jump_count !== 32'd0 || underflow_err !== 1'b0) begin
      n_err++; $display("FAIL reset_counts got %0d/%0d/%b want 0/0/0", retired_count, jump_count, underflow_err); end
    #11 rst = 1; #1;
    n_cmp++; if (bus.wb_ready !== 1'b0) begin n_err++; $display("FAIL release_wb_ready got %b want 0", bus.wb_ready); end
    tick();
    n_cmp++; if (bus.wb_ready !== 1'b1 || bus.reserve_ready !== 1'b1) begin
      n_err++; $display("FAIL after_release_ready got %b/%b want 1/1", bus.wb_ready, bus.reserve_ready); end
  endtask

  task automatic test_commit();
    do_reserve(3);
    rs1_addr = 3; #1;
    n_cmp++; if (rs1_ready !== 1'b0) begin n_err++; $display("FAIL reserved_x3_ready got %b want 0", rs1_ready); end
    do_wb(3, 32'hDEADBEEF, 0, 0); #1;
    n_cmp++; if (rs1_value !== 32'hDEADBEEF) begin n_err++; $display("FAIL commit_x3_value got %h want deadbeef", rs1_value); end
    n_cmp++; if (rs1_ready !== 1'b1) begin n_err++; $display("FAIL commit_x3_ready got %b want 1", rs1_ready); end
    n_cmp++; if (retired_count !== 32'd1) begin n_err++; $display("FAIL commit_retired got %0d want 1", retired_count); end
  endtask

  task automatic test_spec_flush();
    do_reserve(7); do_wb(7, 32'h0BAD0BAD, 0, 0);
    do_reserve(7); do_wb(7, 32'h00001234, 1, 0);
    rs1_addr = 7; #1;
    n_cmp++; if (bus.wb_ready !== 1'b0) begin n_err++; $display("FAIL hold_wb_ready got %b want 0", bus.wb_ready); end
    n_cmp++; if (rs1_value !== 32'h0BAD0BAD) begin n_err++; $display("FAIL hold_x7_value got %h want 0bad0bad", rs1_value); end
    spec_flush = 1; tick(); idle(); #1;
    n_cmp++; if (rs1_value !== 32'h0BAD0BAD || rs1_ready !== 1'b1) begin
      n_err++; $display("FAIL flush_x7 got %h/%b want 0bad0bad/1", rs1_value, rs1_ready); end
    n_cmp++; if (retired_count !== 32'd2) begin n_err++; $display("FAIL flush_retired got %0d want 2", retired_count); end
    n_cmp++; if (bus.wb_ready !== 1'b1) begin n_err++; $display("FAIL flush_wb_ready got %b want 1", bus.wb_ready); end
  endtask

  task automatic test_spec_commit();
    do_reserve(7); do_wb(7, 32'h00001234, 1, 1);
    spec_commit = 1; tick(); idle(); rs1_addr = 7; #1;
    n_cmp++; if (rs1_value !== 32'h00001234 || rs1_ready !== 1'b1) begin
      n_err++; $display("FAIL speccommit_x7 got %h/%b want 00001234/1", rs1_value, rs1_ready); end
    n_cmp++; if (retired_count !== 32'd3 || jump_count !== 32'd1) begin
      n_err++; $display("FAIL speccommit_counts got %0d/%0d want 3/1", retired_count, jump_count); end
    do_reserve(7); do_wb(7, 32'h00005678, 1, 1);
    spec_commit = 1; spec_flush = 1; tick(); idle(); #1;
    n_cmp++; if (rs1_value !== 32'h00001234 || rs1_ready !== 1'b1) begin
      n_err++; $display("FAIL both_x7 got %h/%b want 00001234/1", rs1_value, rs1_ready); end
    n_cmp++; if (retired_count !== 32'd3 || jump_count !== 32'd1 || bus.wb_ready !== 1'b1) begin
      n_err++; $display("FAIL both_counts got %0d/%0d/%b want 3/1/1", retired_count, jump_count, bus.wb_ready); end
  endtask

  task automatic test_reserve_limit();
    do_reserve(9); do_reserve(9); do_reserve(9);
    bus.reserve_addr = 9; rs1_addr = 9; #1;
    n_cmp++; if (bus.reserve_ready !== 1'b0 || rs1_ready !== 1'b0) begin
      n_err++; $display("FAIL full_x9 got %b/%b want 0/0", bus.reserve_ready, rs1_ready); end
    do_wb(9, 32'h99, 0, 0); bus.reserve_addr = 9; #1;
    n_cmp++; if (bus.reserve_ready !== 1'b1) begin n_err++; $display("FAIL x9_after_release got %b want 1", bus.reserve_ready); end
    bus.reserve_valid = 1; bus.wb_valid = 1; bus.wb_addr = 9; bus.wb_value = 32'h9A;
    tick(); idle(); #1;
    n_cmp++; if (bus.reserve_ready !== 1'b1) begin n_err++; $display("FAIL x9_same_cycle got %b want 1", bus.reserve_ready); end
    do_reserve(9); bus.reserve_addr = 9; #1;
    n_cmp++; if (bus.reserve_ready !== 1'b0) begin n_err++; $display("FAIL x9_refull got %b want 0", bus.reserve_ready); end
    do_wb(9, 1, 0, 0); do_wb(9, 2, 0, 0); do_wb(9, 3, 0, 0); #1;
    n_cmp++; if (rs1_ready !== 1'b1 || underflow_err !== 1'b0 || rs1_value !== 32'd3) begin
      n_err++; $display("FAIL x9_drained got %b/%b/%h want 1/0/3", rs1_ready, underflow_err, rs1_value); end
  endtask

  task automatic test_bypass();
    do_reserve(2);
    rs2_addr = 2; bus.wb_valid = 1; bus.wb_addr = 2; bus.wb_value = 32'h55; bus.wb_speculative = 0;
    #1;
`ifdef GECKO_COMMIT_BYPASS_EN
    n_cmp++; if (rs2_value !== 32'h55 || rs2_ready !== 1'b1) begin
      n_err++; $display("FAIL bypass_same_cycle got %h/%b want 55/1", rs2_value, rs2_ready); end
`else
    n_cmp++; if (rs2_value !== 32'h0 || rs2_ready !== 1'b0) begin
      n_err++; $display("FAIL nobypass_same_cycle got %h/%b want 0/0", rs2_value, rs2_ready); end
`endif
    tick(); idle(); #1;
    n_cmp++; if (rs2_value !== 32'h55 || rs2_ready !== 1'b1) begin
      n_err++; $display("FAIL bypass_next_cycle got %h/%b want 55/1", rs2_value, rs2_ready); end
  endtask

  task automatic test_x0_underflow();
    do_wb(0, 32'hFFFFFFFF, 0, 0); rs1_addr = 0; #1;
    n_cmp++; if (rs1_value !== 32'd0 || rs1_ready !== 1'b1 || underflow_err !== 1'b0) begin
      n_err++; $display("FAIL x0_write got %h/%b/%b want 0/1/0", rs1_value, rs1_ready, underflow_err); end
    do_wb(4, 32'h44, 0, 0); rs1_addr = 4; #1;
    n_cmp++; if (underflow_err !== 1'b1 || rs1_ready !== 1'b1 || rs1_value !== 32'h44) begin
      n_err++; $display("FAIL underflow_x4 got %b/%b/%h want 1/1/44", underflow_err, rs1_ready, rs1_value); end
    tick(); tick(); tick();
    n_cmp++; if (underflow_err !== 1'b1) begin n_err++; $display("FAIL underflow_sticky got %b want 1", underflow_err); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 400; it++) begin
      bus.wb_valid = 1'($urandom_range(0, 1)); bus.wb_addr = 5'($urandom_range(0, 7));
      bus.wb_value = $urandom; bus.wb_speculative = ($urandom_range(0, 3) == 0);
      bus.wb_jump_flag = 1'($urandom_range(0, 1)); bus.reserve_valid = 1'($urandom_range(0, 1));
      bus.reserve_addr = 5'($urandom_range(0, 7));
      spec_commit = ($urandom_range(0, 2) == 0); spec_flush = ($urandom_range(0, 3) == 0);
      #1;
      n_cmp++; if (bus.wb_ready !== m_wb_ready() || bus.reserve_ready !== m_res_ready(bus.reserve_addr)) begin
        n_err++; $display("FAIL rnd_ready it=%0d got %b/%b want %b/%b", it, bus.wb_ready, bus.reserve_ready,
                          m_wb_ready(), m_res_ready(bus.reserve_addr)); end
      tick(); idle();
      rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7)); #1;
      n_cmp++; if (rs1_value !== m_regs[rs1_addr] || rs1_ready !== (m_cnt[rs1_addr] == 0)) begin
        n_err++; $display("FAIL rnd_rs1 it=%0d x%0d got %h/%b want %h/%b", it, rs1_addr, rs1_value, rs1_ready,
                          m_regs[rs1_addr], m_cnt[rs1_addr] == 0); end
      n_cmp++; if (rs2_value !== m_regs[rs2_addr] || rs2_ready !== (m_cnt[rs2_addr] == 0)) begin
        n_err++; $display("FAIL rnd_rs2 it=%0d x%0d got %h/%b want %h/%b", it, rs2_addr, rs2_value, rs2_ready,
                          m_regs[rs2_addr], m_cnt[rs2_addr] == 0); end
      n_cmp++; if (retired_count !== m_ret || jump_count !== m_jmp || underflow_err !== m_under) begin
        n_err++; $display("FAIL rnd_counts it=%0d got %0d/%0d/%b want %0d/%0d/%b", it, retired_count, jump_count,
                          underflow_err, m_ret, m_jmp, m_under); end
    end
  endtask

  task automatic test_reset_midstream();
    spec_flush = 1; tick(); idle();
    do_reserve(5); do_reserve(5); do_wb(5, 32'hAAAA5555, 1, 0);
    #1;
    n_cmp++; if (bus.wb_ready !== 1'b0) begin n_err++; $display("FAIL mid_hold_full got %b want 0", bus.wb_ready); end
    rst = 0; model_reset(); rs1_addr = 5; #1;
    n_cmp++; if (bus.wb_ready !== 1'b0 || bus.reserve_ready !== 1'b0 || retired_count !== 32'd0 ||
                 jump_count !== 32'd0 || underflow_err !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_outputs got %b/%b/%0d/%0d/%b want 0/0/0/0/0", bus.wb_ready,
                        bus.reserve_ready, retired_count, jump_count, underflow_err); end
    n_cmp++; if (rs1_value !== 32'd0 || rs1_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_reset_x5 got %h/%b want 0/1", rs1_value, rs1_ready); end
    #2 rst = 1; tick();
    n_cmp++; if (bus.wb_ready !== 1'b1) begin n_err++; $display("FAIL mid_release_wb_ready got %b want 1", bus.wb_ready); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_spec_flush();
    test_spec_commit();
    test_reserve_limit();
    test_bypass();
    test_x0_underflow();
    test_random();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
